multi_hit_judge: RTL and testbench

Parametrised hit judge for the whack-a-mole game core. It tracks up to N_LANES simultaneously active targets, each with its own grid position and reaction window. Decoded key events from the keyboard front end (KeyboardDecoder plus onepulse) are matched against the armed targets, producing sticky per-lane hit/miss flags and running score, miss and combo counters for the display and FSM logic. It sits between the key decode stage and the game controller.

---
 rtl/judge_pkg.sv | 40 ++++
 rtl/judge_lane.sv | 86 ++++++++
 rtl/multi_hit_judge.sv | 136 +++++++++++++
 tb/tb_multi_hit_judge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/judge_pkg.sv
// Shared types and constants for the multi-lane hit judge.
package judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HIT    = 2'd2,
    ST_MISSED = 2'd3
  } lane_state_t;

  localparam int COMBO_W = 4;
  localparam logic [COMBO_W-1:0] COMBO_MAX = 4'd15;

  // PS/2 set-2 make codes of the 3x3 play grid
  localparam logic [7:0] KEY_Q = 8'h15;
  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_E = 8'h24;
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_S = 8'h1B;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_Z = 8'h1A;
  localparam logic [7:0] KEY_X = 8'h22;
  localparam logic [7:0] KEY_C = 8'h21;

  function automatic logic [3:0] key_to_pos(input logic [7:0] code);
    case (code)
      KEY_Q:   key_to_pos = 4'd1;
      KEY_W:   key_to_pos = 4'd2;
      KEY_E:   key_to_pos = 4'd3;
      KEY_A:   key_to_pos = 4'd4;
      KEY_S:   key_to_pos = 4'd5;
      KEY_D:   key_to_pos = 4'd6;
      KEY_Z:   key_to_pos = 4'd7;
      KEY_X:   key_to_pos = 4'd8;
      KEY_C:   key_to_pos = 4'd9;
      default: key_to_pos = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/judge_lane.sv
// One target lane: state machine, reaction-window timer, latched position and sticky flags.
module judge_lane
  import judge_pkg::*;
#(
  parameter int POS_W      = 4,
  parameter int WINDOW_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             round_clr_i,
  input  logic             spawn_i,
  input  logic [POS_W-1:0] spawn_pos_i,
  input  logic             key_ok_i,
  input  logic [POS_W-1:0] key_pos_i,
  input  logic             grant_i,
  output logic             req_o,
  output logic             expire_o,
  output logic             hit_o,
  output logic             miss_o
);

  localparam int TW = $clog2(WINDOW_CYC);
  localparam logic [TW-1:0] T_LOAD = TW'(WINDOW_CYC - 1);

  lane_state_t      state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             hit_q, hit_d, miss_q, miss_d, expire_s;

  // A lane being respawned this cycle may not match the key
  assign req_o    = (state_q == ST_ARMED) && key_ok_i && !spawn_i && (pos_q == key_pos_i);
  assign expire_o = expire_s;
  assign hit_o    = hit_q;
  assign miss_o   = miss_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pos_d    = pos_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    expire_s = 1'b0;
    if (round_clr_i) begin
      state_d = ST_IDLE;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
    end else if (spawn_i) begin
      expire_s = (state_q == ST_ARMED);
      state_d  = ST_ARMED;
      timer_d  = T_LOAD;
      pos_d    = spawn_pos_i;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
    end else if (state_q == ST_ARMED) begin
      if (grant_i) begin
        state_d = ST_HIT;
        hit_d   = 1'b1;
      end else if (timer_q == '0) begin
        state_d  = ST_MISSED;
        miss_d   = 1'b1;
        expire_s = 1'b1;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pos_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

endmodule

// File: rtl/multi_hit_judge.sv
// Multi-lane hit judge: lowest-index key arbitration, wrong-key detection and score/miss/combo counters.
// Build option JUDGE_COMBO_EN: hits score the running combo value instead of 1.
module multi_hit_judge
  import judge_pkg::*;
#(
  parameter int N_LANES    = 4,
  parameter int POS_W      = 4,
  parameter int N_POS      = 9,
  parameter int WINDOW_CYC = 50_000_000,
  parameter int SCORE_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [POS_W-1:0]         key_pos,
  input  logic [N_LANES*POS_W-1:0] lane_pos,
  input  logic [N_LANES-1:0]       lane_spawn,
  input  logic                     round_clr,
  output logic [N_LANES-1:0]       hit,
  output logic [N_LANES-1:0]       miss,
  output logic                     wrong_key,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       miss_cnt,
  output logic [COMBO_W-1:0]       combo
);

  localparam int EV_W = $clog2(N_LANES + 2);
  localparam int SW1  = SCORE_W + 1;

  logic               key_ok_s, wrong_s, hit_any_s;
  logic [N_LANES-1:0] spawn_ok_s, req_s, grant_s, expire_s;
  logic [EV_W-1:0]    ev_s;
  logic [SW1-1:0]     score_add_s, score_sum_s, miss_sum_s;
  logic [SCORE_W-1:0] score_q, score_d, miss_cnt_q, miss_cnt_d;
  logic               wrong_key_q;

  assign key_ok_s = key_valid && (key_pos != '0) && !round_clr;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [POS_W-1:0] pos_s;
    assign pos_s = lane_pos[i*POS_W +: POS_W];
    assign spawn_ok_s[i] = lane_spawn[i] && (pos_s != '0) && (pos_s <= POS_W'(N_POS)) && !round_clr;

    judge_lane #(
      .POS_W      (POS_W),
      .WINDOW_CYC (WINDOW_CYC)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .round_clr_i (round_clr),
      .spawn_i     (spawn_ok_s[i]),
      .spawn_pos_i (pos_s),
      .key_ok_i    (key_ok_s),
      .key_pos_i   (key_pos),
      .grant_i     (grant_s[i]),
      .req_o       (req_s[i]),
      .expire_o    (expire_s[i]),
      .hit_o       (hit[i]),
      .miss_o      (miss[i])
    );
  end

  // Isolate the lowest set request bit so one key hits one lane
  assign grant_s   = req_s & (~req_s + N_LANES'(1));
  assign hit_any_s = |req_s;
  assign wrong_s   = key_ok_s && !hit_any_s;

  always_comb begin
    ev_s = EV_W'(wrong_s);
    for (int i = 0; i < N_LANES; i++) begin
      ev_s = ev_s + EV_W'(expire_s[i]);
    end
  end

`ifdef JUDGE_COMBO_EN
  logic [COMBO_W-1:0] combo_q, combo_d, combo_inc_s;

  // A hit on a cycle that also has a miss still scores the incremented combo
  always_comb begin
    combo_inc_s = (combo_q == COMBO_MAX) ? COMBO_MAX : combo_q + COMBO_W'(1);
    score_add_s = SW1'(combo_inc_s);
    if (ev_s != '0) begin
      combo_d = '0;
    end else if (hit_any_s) begin
      combo_d = combo_inc_s;
    end else begin
      combo_d = combo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      combo_q <= '0;
    end else begin
      combo_q <= combo_d;
    end
  end

  assign combo = combo_q;
`else
  assign score_add_s = SW1'(1);
  assign combo       = '0;
`endif

  always_comb begin
    score_sum_s = {1'b0, score_q} + (hit_any_s ? score_add_s : SW1'(0));
    miss_sum_s  = {1'b0, miss_cnt_q} + SW1'(ev_s);
    if (score_sum_s[SCORE_W]) begin
      score_d = '1;
    end else begin
      score_d = score_sum_s[SCORE_W-1:0];
    end
    if (miss_sum_s[SCORE_W]) begin
      miss_cnt_d = '1;
    end else begin
      miss_cnt_d = miss_sum_s[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q     <= '0;
      miss_cnt_q  <= '0;
      wrong_key_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      miss_cnt_q  <= miss_cnt_d;
      wrong_key_q <= wrong_s;
    end
  end

  assign score     = score_q;
  assign miss_cnt  = miss_cnt_q;
  assign wrong_key = wrong_key_q;

endmodule

// File: tb/tb_multi_hit_judge.sv
// Scoreboard bench for multi_hit_judge; expectations from a deadline-based lane model.
module tb_multi_hit_judge;

  localparam int NL   = 4;
  localparam int PW   = 4;
  localparam int NP   = 9;
  localparam int WC   = 8;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;
  localparam int S_I = 0, S_A = 1, S_H = 2, S_M = 3;
`ifdef JUDGE_COMBO_EN
  localparam int EXP3_SCORE = 6;
  localparam int EXP3_COMBO = 3;
`else
  localparam int EXP3_SCORE = 3;
  localparam int EXP3_COMBO = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          key_valid;
  logic [PW-1:0] key_pos;
  logic [NL*PW-1:0] lane_pos;
  logic [NL-1:0] lane_spawn;
  logic          round_clr;
  logic [NL-1:0] hit, miss;
  logic          wrong_key;
  logic [SW-1:0] score, miss_cnt;
  logic [3:0]    combo;

  multi_hit_judge #(
    .N_LANES(NL), .POS_W(PW), .N_POS(NP), .WINDOW_CYC(WC), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_pos(key_pos),
    .lane_pos(lane_pos), .lane_spawn(lane_spawn), .round_clr(round_clr),
    .hit(hit), .miss(miss), .wrong_key(wrong_key), .score(score),
    .miss_cnt(miss_cnt), .combo(combo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hit;
    int miss;
    int wrong;
    int score;
    int mcnt;
    int combo;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  int m_state[NL];
  int m_dl[NL];
  int m_pos[NL];
  int m_hit, m_miss, m_score, m_mcnt, m_combo;
  int now;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0d expected=%0d", tag, now, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_state[i] = S_I;
      m_dl[i]    = 0;
      m_pos[i]   = 0;
    end
    m_hit = 0; m_miss = 0; m_score = 0; m_mcnt = 0; m_combo = 0;
  endtask

  task automatic model_step();
    int ev, matched, wrong, add, p;
    bit spn[NL];
    exp_t e;
    ev = 0; matched = -1; wrong = 0;
    if (round_clr) begin
      for (int i = 0; i < NL; i++) m_state[i] = S_I;
      m_hit = 0; m_miss = 0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        p = int'(lane_pos[i*PW +: PW]);
        spn[i] = lane_spawn[i] && p != 0 && p <= NP;
      end
      if (key_valid && key_pos != 0) begin
        for (int i = 0; i < NL; i++)
          if (matched < 0 && !spn[i] && m_state[i] == S_A && m_pos[i] == int'(key_pos) && now <= m_dl[i])
            matched = i;
        if (matched < 0) wrong = 1;
      end
      for (int i = 0; i < NL; i++) begin
        if (spn[i]) begin
          if (m_state[i] == S_A) ev++;
          m_state[i] = S_A;
          m_dl[i]    = now + WC;
          m_pos[i]   = int'(lane_pos[i*PW +: PW]);
          m_hit  &= ~(1 << i);
          m_miss &= ~(1 << i);
        end else if (i == matched) begin
          m_state[i] = S_H;
          m_hit |= (1 << i);
        end else if (m_state[i] == S_A && now == m_dl[i]) begin
          m_state[i] = S_M;
          m_miss |= (1 << i);
          ev++;
        end
      end
      ev += wrong;
`ifdef JUDGE_COMBO_EN
      add = (m_combo + 1 > 15) ? 15 : m_combo + 1;
`else
      add = 1;
`endif
      if (matched >= 0) m_score = (m_score + add > SMAX) ? SMAX : m_score + add;
      m_mcnt = (m_mcnt + ev > SMAX) ? SMAX : m_mcnt + ev;
`ifdef JUDGE_COMBO_EN
      if (ev > 0) m_combo = 0;
      else if (matched >= 0) m_combo = add;
`else
      m_combo = 0;
`endif
    end
    e.hit = m_hit; e.miss = m_miss; e.wrong = wrong;
    e.score = m_score; e.mcnt = m_mcnt; e.combo = m_combo;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    now++;
    e = sb_q.pop_front();
    check_val("hit", 32'(hit), e.hit);
    check_val("miss", 32'(miss), e.miss);
    check_val("wrong_key", 32'(wrong_key), e.wrong);
    check_val("score", 32'(score), e.score);
    check_val("miss_cnt", 32'(miss_cnt), e.mcnt);
    check_val("combo", 32'(combo), e.combo);
    key_valid = 1'b0; key_pos = '0; lane_spawn = '0; round_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic spawn(input int lane, input int pos);
    lane_pos[lane*PW +: PW] = PW'(pos);
    lane_spawn[lane] = 1'b1;
  endtask

  task automatic key(input int pos);
    key_valid = 1'b1;
    key_pos   = PW'(pos);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_pos = '0; lane_pos = '0;
    lane_spawn = '0; round_clr = 1'b0; now = 0;
    model_reset();
    #23;
    check_val("rst_hit", 32'(hit), 0);
    check_val("rst_miss", 32'(miss), 0);
    check_val("rst_score", 32'(score), 0);
    check_val("rst_miss_cnt", 32'(miss_cnt), 0);
    check_val("rst_combo", 32'(combo), 0);
    check_val("rst_wrong", 32'(wrong_key), 0);
    rst = 1'b0;

    spawn(0, 5); cyc(); idle(2);
    key(5); cyc();
    check_val("single_hit", 32'(hit), 1);
    check_val("single_score", 32'(score), 1);
    cyc();

    spawn(1, 2); cyc(); idle(7);
    check_val("expiry_early", 32'(miss[1]), 0);
    cyc();
    check_val("expiry_at_w1", 32'(miss[1]), 1);
    check_val("expiry_combo", 32'(combo), 0);

    spawn(0, 7); spawn(2, 7); cyc();
    key(7); cyc();
    check_val("shared_first", 32'(hit), 32'h1);
    key(7); cyc();
    check_val("shared_second", 32'(hit), 32'h5);

    key(3); cyc();
    check_val("wrong_pulse", 32'(wrong_key), 1);
    cyc();
    check_val("wrong_drop", 32'(wrong_key), 0);
    key(0); cyc();
    key(7); cyc();

    spawn(3, 9); cyc(); idle(7);
    key(9); cyc();
    check_val("last_cycle_hit", 32'(hit[3]), 1);
    spawn(3, 8); cyc(); idle(8);
    key(8); cyc();
    check_val("late_key_wrong", 32'(wrong_key), 1);

    spawn(0, 4); cyc();
    round_clr = 1'b1; key(4); cyc();
    check_val("clr_hit", 32'(hit), 0);
    round_clr = 1'b1; spawn(1, 3); cyc(); idle(10);

    spawn(2, 6); cyc();
    spawn(2, 0); cyc();
    spawn(2, 12); cyc();
    key(6); cyc();
    check_val("bad_spawn_ignored", 32'(hit[2]), 1);

    spawn(1, 1); cyc();
    spawn(1, 2); cyc();
    key(2); cyc();

    spawn(0, 5); cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    check_val("async_hit", 32'(hit), 0);
    check_val("async_score", 32'(score), 0);
    check_val("async_miss_cnt", 32'(miss_cnt), 0);
    model_reset();
    #4 rst = 1'b0;
    idle(10);
    check_val("async_no_miss", 32'(miss_cnt), 0);

    for (int k = 0; k < 3; k++) begin
      spawn(k, k + 1); cyc();
      key(k + 1); cyc();
    end
    check_val("three_score", 32'(score), EXP3_SCORE);
    check_val("three_combo", 32'(combo), EXP3_COMBO);

    for (int k = 0; k < 17; k++) begin
      spawn(0, 1); cyc();
      key(1); cyc();
    end
    check_val("score_sat", 32'(score), SMAX);

    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 99) < 25) spawn($urandom_range(0, NL - 1), $urandom_range(0, 11));
      if ($urandom_range(0, 99) < 35) key($urandom_range(0, 10));
      if ($urandom_range(0, 99) < 3) round_clr = 1'b1;
      cyc();
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
